// File: rtl/operand_entry.sv
// operand_entry: builds the 32-bit ALU operands A and B one byte at a time from the
// data switches. A debounced LOAD press writes SW into the next byte. A debounced CLR
// press zeroes both operands.

// Per-button conditioning: a 2-FF synchronizer, then a debounce counter, then a
// registered single-cycle press pulse.
module operand_entry_db #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic             s1, s2, db, db_q;
  logic [CNT_W-1:0] cnt;

  // Synchronize, accept a new level after DEBOUNCE_CYCLES stable samples, then edge-detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; db <= 1'b0; db_q <= 1'b0;
      press <= 1'b0; cnt <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      db_q  <= db;
      press <= db & ~db_q;
      if (s2 == db)
        cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  SW,
  input  logic        BTN_LOAD,
  input  logic        BTN_CLR,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [1:0]  BYTE_IDX,
  output logic        SEL_B,
  output logic        VALID,
  output logic        LOAD_ACK
);
  typedef enum logic [1:0] {ENTER_A, ENTER_B, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] a_n, b_n;
  logic [1:0]  idx_n;
  logic        ack_n;
  logic [1:0]  raw, press;

  // Bit 0 is LOAD and bit 1 is CLR. Both buttons use the same debouncer.
  assign raw = {BTN_CLR, BTN_LOAD};

  operand_entry_db #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db [1:0] (
    .clk  (clk),
    .rst  (rst),
    .btn  (raw),
    .press(press)
  );

  // State and operand registers. SEL_B and VALID are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ENTER_A;
      A        <= '0;
      B        <= '0;
      BYTE_IDX <= '0;
      SEL_B    <= 1'b0;
      VALID    <= 1'b0;
      LOAD_ACK <= 1'b0;
    end else begin
      state    <= state_n;
      A        <= a_n;
      B        <= b_n;
      BYTE_IDX <= idx_n;
      SEL_B    <= (state_n == ENTER_B);
      VALID    <= (state_n == DONE);
      LOAD_ACK <= ack_n;
    end
  end

  // Next-state logic. CLR takes priority and discards a LOAD press on the same edge.
  always_comb begin
    state_n = state;
    a_n     = A;
    b_n     = B;
    idx_n   = BYTE_IDX;
    ack_n   = 1'b0;
    if (press[1]) begin
      a_n     = '0;
      b_n     = '0;
      state_n = ENTER_A;
      idx_n   = '0;
    end else if (press[0]) begin
      case (state)
        ENTER_A: begin
          a_n[{BYTE_IDX, 3'b000} +: 8] = SW;
          ack_n = 1'b1;
          idx_n = BYTE_IDX + 2'd1;
          if (BYTE_IDX == 2'd3) state_n = ENTER_B;
        end
        ENTER_B: begin
          b_n[{BYTE_IDX, 3'b000} +: 8] = SW;
          ack_n = 1'b1;
          idx_n = BYTE_IDX + 2'd1;
          if (BYTE_IDX == 2'd3) state_n = DONE;
        end
        default: begin
          // A press in DONE starts a new entry round. It writes nothing, and the old
          // values remain until later presses overwrite them.
          state_n = ENTER_A;
          idx_n   = '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry with DEBOUNCE_CYCLES=4. A position model (bytes entered so
// far, 0..8) predicts the operands and the status outputs.
module tb_operand_entry;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  SW = '0;
  logic        BTN_LOAD = 1'b0, BTN_CLR = 1'b0;
  logic [31:0] A, B;
  logic [1:0]  BYTE_IDX;
  logic        SEL_B, VALID, LOAD_ACK;

  int total = 0, bad = 0;
  int ack_total = 0;

  // Reference model. pos counts the bytes written since the last clear or wrap,
  // and pos == 8 means both operands are complete.
  int          pos = 0;
  logic [31:0] m_a = '0, m_b = '0;

  operand_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .SW(SW), .BTN_LOAD(BTN_LOAD), .BTN_CLR(BTN_CLR),
    .A(A), .B(B), .BYTE_IDX(BYTE_IDX), .SEL_B(SEL_B), .VALID(VALID), .LOAD_ACK(LOAD_ACK)
  );

  always #5 clk = ~clk;

  // Count LOAD_ACK high cycles on the falling edge.
  always @(negedge clk) if (LOAD_ACK) ack_total++;

  function automatic int model_load(input logic [7:0] sw);
    if (pos == 8) begin pos = 0; return 0; end
    if (pos < 4) m_a[8*pos +: 8] = sw;
    else         m_b[8*(pos-4) +: 8] = sw;
    pos++;
    return 1;
  endfunction

  function automatic void model_clear();
    m_a = '0; m_b = '0; pos = 0;
  endfunction

  // Expected value of {A, B, BYTE_IDX, SEL_B, VALID}.
  function automatic logic [67:0] exp_vec();
    logic [1:0] idx;
    idx = (pos == 8) ? 2'd0 : 2'(pos % 4);
    return {m_a, m_b, idx, (pos >= 4 && pos < 8), (pos == 8)};
  endfunction

  // Hold the selected buttons for `hold` edges after the first sampling edge, then
  // release and let the release settle. lat is the edge number of the first ACK,
  // or -1 if no ACK appeared.
  task automatic press(input logic [1:0] which, input logic [7:0] sw, input int hold,
                       output int acks, output int lat);
    int a0;
    SW = sw;
    @(negedge clk);
    BTN_LOAD = which[0]; BTN_CLR = which[1];
    a0 = ack_total; lat = -1;
    @(posedge clk);
    for (int n = 1; n <= hold; n++) begin
      @(posedge clk); #1;
      if (LOAD_ACK && lat < 0) lat = n;
    end
    @(negedge clk);
    BTN_LOAD = 1'b0; BTN_CLR = 1'b0;
    repeat (D + 6) @(negedge clk);
    acks = ack_total - a0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({A, B, BYTE_IDX, SEL_B, VALID, LOAD_ACK} !== 69'd0) begin
      bad++; $display("FAIL reset_hold: got %h want 0", {A, B, BYTE_IDX, SEL_B, VALID, LOAD_ACK});
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({A, B, BYTE_IDX, SEL_B, VALID, LOAD_ACK} !== 69'd0) begin
      bad++; $display("FAIL reset_idle: got %h want 0", {A, B, BYTE_IDX, SEL_B, VALID, LOAD_ACK});
    end
  endtask

  task automatic test_single();
    int acks, lat, e;
    press(2'b01, 8'h5A, 20, acks, lat);
    e = model_load(8'h5A);
    total++;
    if (lat !== D + 3) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, D + 3); end
    total++;
    if (acks !== e) begin bad++; $display("FAIL single_ack_count: got %0d want %0d", acks, e); end
    total++;
    if ({A, BYTE_IDX, SEL_B} !== {32'h0000005A, 2'd1, 1'b0}) begin
      bad++; $display("FAIL single_out: got A=%h idx=%0d selb=%b want A=5a idx=1 selb=0", A, BYTE_IDX, SEL_B);
    end
  endtask

  task automatic test_sequence();
    int acks, lat, e;
    press(2'b10, 8'h00, 12, acks, lat);
    model_clear();
    for (int i = 1; i <= 8; i++) begin
      press(2'b01, 8'(i * 8'h11), 10, acks, lat);
      e = model_load(8'(i * 8'h11));
      total++;
      if (acks !== e || exp_vec() !== {A, B, BYTE_IDX, SEL_B, VALID}) begin
        bad++; $display("FAIL seq_byte%0d: got acks=%0d out=%h want acks=%0d out=%h",
                        i, acks, {A, B, BYTE_IDX, SEL_B, VALID}, e, exp_vec());
      end
    end
    total++;
    if ({A, B, BYTE_IDX, SEL_B, VALID} !== {32'h44332211, 32'h88776655, 2'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL seq_done: got A=%h B=%h idx=%0d selb=%b valid=%b", A, B, BYTE_IDX, SEL_B, VALID);
    end
    press(2'b01, 8'h99, 10, acks, lat);
    e = model_load(8'h99);
    total++;
    if (acks !== 0 || e !== 0 || {A, B, BYTE_IDX, SEL_B, VALID} !== {32'h44332211, 32'h88776655, 4'd0}) begin
      bad++; $display("FAIL seq_ninth: got acks=%0d A=%h B=%h valid=%b want acks=0 A/B kept valid=0",
                      acks, A, B, VALID);
    end
  endtask

  task automatic test_bounce();
    int a0, acks, e;
    logic [7:0] sw;
    for (int r = 0; r < 3; r++) begin
      sw = 8'($urandom); SW = sw;
      a0 = ack_total;
      repeat ($urandom_range(2, 4)) begin
        @(negedge clk); BTN_LOAD = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        BTN_LOAD = 1'b0;
        repeat ($urandom_range(1, 3) - 1) @(negedge clk);
      end
      @(negedge clk); BTN_LOAD = 1'b1;
      repeat (10) @(negedge clk);
      BTN_LOAD = 1'b0;
      repeat (D + 6) @(negedge clk);
      acks = ack_total - a0;
      e = model_load(sw);
      total++;
      if (acks !== e || exp_vec() !== {A, B, BYTE_IDX, SEL_B, VALID}) begin
        bad++; $display("FAIL bounce%0d: got acks=%0d out=%h want acks=%0d out=%h",
                        r, acks, {A, B, BYTE_IDX, SEL_B, VALID}, e, exp_vec());
      end
    end
    a0 = ack_total;
    @(negedge clk); BTN_LOAD = 1'b1;
    repeat (3) @(negedge clk);
    BTN_LOAD = 1'b0;
    repeat (15) @(negedge clk);
    total++;
    if (ack_total - a0 !== 0 || exp_vec() !== {A, B, BYTE_IDX, SEL_B, VALID}) begin
      bad++; $display("FAIL glitch: got acks=%0d out=%h want acks=0 out=%h",
                      ack_total - a0, {A, B, BYTE_IDX, SEL_B, VALID}, exp_vec());
    end
  endtask

  task automatic test_clear();
    int acks, lat, e;
    for (int i = 0; i < 5; i++) begin
      press(2'b01, 8'($urandom), 10, acks, lat);
      e = model_load(SW);
    end
    press(2'b10, 8'h00, 10, acks, lat);
    model_clear();
    total++;
    if (acks !== 0 || {A, B, BYTE_IDX, SEL_B, VALID} !== 68'd0) begin
      bad++; $display("FAIL clear: got acks=%0d out=%h want acks=0 out=0", acks, {A, B, BYTE_IDX, SEL_B, VALID});
    end
    for (int i = 0; i < 2; i++) begin
      press(2'b01, 8'($urandom_range(1, 255)), 10, acks, lat);
      e = model_load(SW);
    end
    press(2'b11, 8'hC3, 10, acks, lat);
    model_clear();
    total++;
    if (acks !== 0 || {A, B, BYTE_IDX, SEL_B, VALID} !== 68'd0) begin
      bad++; $display("FAIL clear_and_load: got acks=%0d out=%h want acks=0 out=0",
                      acks, {A, B, BYTE_IDX, SEL_B, VALID});
    end
  endtask

  task automatic test_random();
    int acks, lat, e;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        press(2'b10, 8'($urandom), 8 + $urandom_range(0, 6), acks, lat);
        model_clear();
        e = 0;
      end else begin
        press(2'b01, 8'($urandom), 8 + $urandom_range(0, 6), acks, lat);
        e = model_load(SW);
      end
      total++;
      if (acks !== e || exp_vec() !== {A, B, BYTE_IDX, SEL_B, VALID}) begin
        bad++; $display("FAIL random%0d: got acks=%0d out=%h want acks=%0d out=%h",
                        i, acks, {A, B, BYTE_IDX, SEL_B, VALID}, e, exp_vec());
      end
    end
  endtask

  task automatic test_rst_mid();
    int a0, lat, e;
    logic [7:0] sw;
    sw = 8'($urandom); SW = sw;
    @(negedge clk); BTN_LOAD = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({A, B, BYTE_IDX, SEL_B, VALID, LOAD_ACK} !== 69'd0) begin
      bad++; $display("FAIL rst_mid_async: got %h want 0", {A, B, BYTE_IDX, SEL_B, VALID, LOAD_ACK});
    end
    repeat (3) @(negedge clk);
    total++;
    if ({A, B, BYTE_IDX, SEL_B, VALID, LOAD_ACK} !== 69'd0) begin
      bad++; $display("FAIL rst_mid_hold: got %h want 0", {A, B, BYTE_IDX, SEL_B, VALID, LOAD_ACK});
    end
    model_clear();
    rst = 1'b0;
    a0 = ack_total; lat = -1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (LOAD_ACK && lat < 0) lat = n;
    end
    @(negedge clk); BTN_LOAD = 1'b0;
    repeat (D + 6) @(negedge clk);
    e = model_load(sw);
    total++;
    if (lat !== D + 3 || ack_total - a0 !== e) begin
      bad++; $display("FAIL rst_mid_press: got lat=%0d acks=%0d want lat=%0d acks=%0d",
                      lat, ack_total - a0, D + 3, e);
    end
    total++;
    if (exp_vec() !== {A, B, BYTE_IDX, SEL_B, VALID}) begin
      bad++; $display("FAIL rst_mid_out: got %h want %h", {A, B, BYTE_IDX, SEL_B, VALID}, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_bounce();
    test_clear();
    test_random();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the bench stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
